fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared defines for the instruction fetch controller: state encoding,
// reset/bubble defaults and the control-transfer opcodes the hazard unit keys on.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_REDIR = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;

endpackage

// File: rtl/fetch_ctrl.sv
// IF stage controller: drives the fetch PC, loads IF/ID, inserts bubbles on
// control-hazard stalls and redirects, and flags stall timeouts / misaligned targets.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal sequential fetch
// ST_STALL | jump hazard pending, pc held and bubbles inserted
// ST_REDIR | redirect just taken, residual stall_jump ignored for one edge
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST  = DEF_NOP_INST,
    parameter int          MAX_STALL = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_jump,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] inst_in,
    output logic [31:0] pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [15:0] bubble_cnt,
    output logic        stall_timeout,
    output logic        misalign_err
);

    localparam int SCW = $clog2(MAX_STALL + 2);
    localparam logic [SCW-1:0] STALL_LIMIT = SCW'(MAX_STALL + 1);

    fetch_state_e   state_q;
    logic [31:0]    pc_q;
    logic [31:0]    if_id_inst_q;
    logic [31:0]    if_id_pc_q;
    logic [31:0]    if_id_pc4_q;
    logic           if_id_valid_q;
    logic [15:0]    bubble_cnt_q;
    logic           stall_timeout_q;
    logic           misalign_err_q;
    logic [SCW-1:0] stall_cnt_q;

    logic [31:0]    pc_plus4_d;
    logic [15:0]    bubble_cnt_d;
    logic [SCW-1:0] stall_cnt_d;

    always_comb begin
        pc_plus4_d   = pc_q + 32'd4;
        bubble_cnt_d = (bubble_cnt_q == 16'hFFFF) ? bubble_cnt_q : bubble_cnt_q + 16'd1;
        stall_cnt_d  = stall_cnt_q;
        if (state_q != ST_STALL) begin
            stall_cnt_d = SCW'(1);
        end else if (stall_cnt_q != STALL_LIMIT) begin
            stall_cnt_d = stall_cnt_q + SCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_RUN;
            pc_q            <= RESET_PC;
            if_id_inst_q    <= NOP_INST;
            if_id_pc_q      <= 32'h0;
            if_id_pc4_q     <= 32'h0;
            if_id_valid_q   <= 1'b0;
            bubble_cnt_q    <= 16'h0;
            stall_timeout_q <= 1'b0;
            misalign_err_q  <= 1'b0;
            stall_cnt_q     <= '0;
        end else if (redirect_valid) begin
            // Low address bits are dropped; the flag records the bad target.
            pc_q          <= {redirect_pc[31:2], 2'b00};
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
            bubble_cnt_q  <= bubble_cnt_d;
            stall_cnt_q   <= '0;
            state_q       <= ST_REDIR;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err_q <= 1'b1;
            end
        end else if (stall_jump && state_q != ST_REDIR) begin
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
            bubble_cnt_q  <= bubble_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            state_q       <= ST_STALL;
            if (stall_cnt_d == STALL_LIMIT) begin
                stall_timeout_q <= 1'b1;
            end
        end else begin
            if_id_inst_q  <= inst_in;
            if_id_pc_q    <= pc_q;
            if_id_pc4_q   <= pc_plus4_d;
            if_id_valid_q <= 1'b1;
            pc_q          <= pc_plus4_d;
            stall_cnt_q   <= '0;
            state_q       <= ST_RUN;
        end
    end

    assign pc            = pc_q;
    assign if_id_inst    = if_id_inst_q;
    assign if_id_pc      = if_id_pc_q;
    assign if_id_pc4     = if_id_pc4_q;
    assign if_id_valid   = if_id_valid_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign stall_timeout = stall_timeout_q;
    assign misalign_err  = misalign_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, stalls, redirects,
// misalignment, stall timeout, async reset and PC wrap.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hA500_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_jump;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst_in;
    logic [31:0] pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [15:0] bubble_cnt;
    logic        stall_timeout;
    logic        misalign_err;

    int checks = 0;
    int failures = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall_jump     (stall_jump),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_in        (inst_in),
        .pc             (pc),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .bubble_cnt     (bubble_cnt),
        .stall_timeout  (stall_timeout),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    // ROM model: each word is tagged with its own address.
    assign inst_in = pc ^ TAG;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"},    pc, 32'h0);
        chk({tag, ".inst"},  if_id_inst, NOP);
        chk({tag, ".ifpc"},  if_id_pc, 32'h0);
        chk({tag, ".pc4"},   if_id_pc4, 32'h0);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'h0);
        chk({tag, ".bcnt"},  32'(bubble_cnt), 32'h0);
        chk({tag, ".tmo"},   32'(stall_timeout), 32'h0);
        chk({tag, ".mis"},   32'(misalign_err), 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        stall_jump = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        #12;
        chk_reset("rst0");
        @(posedge clk);
        #3;
        rst = 1'b1;

        // sequential fetch
        tick();
        chk("seq1.pc", pc, 32'h4);
        chk("seq1.ifpc", if_id_pc, 32'h0);
        chk("seq1.inst", if_id_inst, 32'h0 ^ TAG);
        chk("seq1.pc4", if_id_pc4, 32'h4);
        chk("seq1.valid", 32'(if_id_valid), 32'h1);
        tick();
        chk("seq2.pc", pc, 32'h8);
        chk("seq2.ifpc", if_id_pc, 32'h4);

        // two-cycle jump stall at pc=8
        stall_jump = 1'b1;
        tick();
        chk("stl1.pc", pc, 32'h8);
        chk("stl1.inst", if_id_inst, NOP);
        chk("stl1.valid", 32'(if_id_valid), 32'h0);
        chk("stl1.ifpc", if_id_pc, 32'h4);
        tick();
        chk("stl2.pc", pc, 32'h8);
        chk("stl2.bcnt", 32'(bubble_cnt), 32'h2);
        stall_jump = 1'b0;
        tick();
        chk("stl3.ifpc", if_id_pc, 32'h8);
        chk("stl3.inst", if_id_inst, 32'h8 ^ TAG);
        chk("stl3.valid", 32'(if_id_valid), 32'h1);
        chk("stl3.pc", pc, 32'hC);

        // redirect wins over stall, residual stall ignored in REDIR
        stall_jump = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        chk("rd1.pc", pc, 32'h40);
        chk("rd1.valid", 32'(if_id_valid), 32'h0);
        chk("rd1.inst", if_id_inst, NOP);
        chk("rd1.bcnt", 32'(bubble_cnt), 32'h3);
        redirect_valid = 1'b0;
        tick();
        chk("rd2.ifpc", if_id_pc, 32'h40);
        chk("rd2.inst", if_id_inst, 32'h40 ^ TAG);
        chk("rd2.valid", 32'(if_id_valid), 32'h1);
        chk("rd2.pc", pc, 32'h44);
        stall_jump = 1'b0;

        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        tick();
        chk("mis1.pc", pc, 32'h40);
        chk("mis1.flag", 32'(misalign_err), 32'h1);
        redirect_valid = 1'b0;
        tick();
        chk("mis2.pc", pc, 32'h44);
        chk("mis2.ifpc", if_id_pc, 32'h40);
        chk("mis2.flag", 32'(misalign_err), 32'h1);

        // back-to-back redirects: second one honoured in REDIR
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_pc = 32'h200;
        tick();
        chk("rr1.pc", pc, 32'h200);
        chk("rr1.valid", 32'(if_id_valid), 32'h0);
        redirect_valid = 1'b0;
        tick();
        chk("rr2.ifpc", if_id_pc, 32'h200);
        chk("rr2.pc", pc, 32'h204);

        // fresh reset, then stall timeout
        #2;
        rst = 1'b0;
        #1;
        chk_reset("rst1");
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("to0.pc", pc, 32'h4);
        stall_jump = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("to8.flag", 32'(stall_timeout), 32'h0);
        chk("to8.bcnt", 32'(bubble_cnt), 32'h8);
        tick();
        chk("to9.flag", 32'(stall_timeout), 32'h1);
        chk("to9.bcnt", 32'(bubble_cnt), 32'h9);
        chk("to9.pc", pc, 32'h4);
        tick();
        chk("to10.flag", 32'(stall_timeout), 32'h1);

        // asynchronous reset mid-stall
        #2;
        rst = 1'b0;
        #1;
        chk_reset("rst2");
        stall_jump = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post.pc", pc, 32'h4);
        chk("post.ifpc", if_id_pc, 32'h0);
        chk("post.valid", 32'(if_id_valid), 32'h1);

        // 32-bit PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk("wrap1.pc", pc, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick();
        chk("wrap2.pc", pc, 32'h0);
        chk("wrap2.ifpc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap2.pc4", if_id_pc4, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
